bit_index_decoder: RTL

BIT_INDEX_DECODER -- requirements
Module: bit_index_decoder

---
 rtl/bloom_pkg.sv | 21 ++
 rtl/bit_index_decoder_scan_cursor.sv | 40 ++++
 rtl/bit_index_decoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bloom_pkg.sv
// Shared definitions for the bit index decoder.
//   state_e : scan FSM states
//   DEF_N   : default bit-array width
//   idx_w() : index width for an N-bit array
// Optional feature macro used by importers: BIT_INDEX_DECODER_COUNT_EN
package bloom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEF_N = 32;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bit_index_decoder_scan_cursor.sv
// scan_cursor: bit-position cursor for the decoder scan.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : return cursor to 0 (new array loaded)
//   inc      : advance cursor by one
//   cursor   : current bit position
//   last     : cursor is at N-1
module scan_cursor #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] cursor,
  output logic             last
);

  logic [IDX_W-1:0] cursor_q, cursor_d;

  assign last   = (cursor_q == IDX_W'(N - 1));
  assign cursor = cursor_q;

  // Increment is suppressed at the terminal count so the cursor can never
  // wrap, even if the controller asks for it.
  always_comb begin
    cursor_d = cursor_q;
    if (clr)
      cursor_d = '0;
    else if (inc && !last)
      cursor_d = cursor_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cursor_q <= '0;
    else     cursor_q <= cursor_d;
  end

endmodule

// File: rtl/bit_index_decoder.sv
// bit_index_decoder: accepts an N-bit array and emits the index of every
// set bit in ascending order over a valid/ready stream, then pulses done.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   load_valid/load_ready  : array handshake, load_bits is the array
//   idx_valid/idx_ready    : index handshake, idx is the set-bit index
//   done                   : one-cycle pulse at end of each scan
//   hit_count              : indices accepted this scan
//                            (only with BIT_INDEX_DECODER_COUNT_EN)
module bit_index_decoder
  import bloom_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [N-1:0]     load_bits,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] idx,
  output logic             done
`ifdef BIT_INDEX_DECODER_COUNT_EN
  ,
  output logic [IDX_W:0]   hit_count
`endif
);

  state_e           state_q, state_d;
  logic [N-1:0]     bits_q, bits_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cursor;
  logic             last;
  logic             cur_clr, cur_inc;
  logic             load_acc, idx_hs;

  // Outputs are masked while rst is high so the reset values appear in the
  // same cycle rst is asserted, not one edge later.
  assign load_ready = !rst && (state_q == ST_IDLE);
  assign idx_valid  = !rst && (state_q == ST_EMIT);
  assign done       = !rst && (state_q == ST_DONE);
  assign idx        = rst ? '0 : idx_q;

  assign load_acc = load_valid && load_ready;
  assign idx_hs   = idx_valid && idx_ready;

  scan_cursor #(.N(N), .IDX_W(IDX_W)) u_cursor (
    .clk    (clk),
    .rst    (rst),
    .clr    (cur_clr),
    .inc    (cur_inc),
    .cursor (cursor),
    .last   (last)
  );

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    idx_d   = idx_q;
    cur_clr = 1'b0;
    cur_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_acc) begin
          bits_d  = load_bits;
          cur_clr = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (bits_q[cursor]) begin
          idx_d   = cursor;
          state_d = ST_EMIT;
        end else if (last) begin
          state_d = ST_DONE;
        end else begin
          cur_inc = 1'b1;
        end
      end
      ST_EMIT: begin
        if (idx_hs) begin
          if (last) begin
            state_d = ST_DONE;
          end else begin
            cur_inc = 1'b1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bits_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      idx_q   <= idx_d;
    end
  end

`ifdef BIT_INDEX_DECODER_COUNT_EN
  logic [IDX_W:0] hit_count_q, hit_count_d;

  // Cleared on a new load, not on done, so the final count stays readable
  // through DONE and IDLE.
  always_comb begin
    hit_count_d = hit_count_q;
    if (load_acc)
      hit_count_d = '0;
    else if (idx_hs)
      hit_count_d = hit_count_q + (IDX_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) hit_count_q <= '0;
    else     hit_count_q <= hit_count_d;
  end

  assign hit_count = rst ? '0 : hit_count_q;
`endif

endmodule
